wb_test_checker: RTL and testbench

WB_TEST_CHECKER -- requirements
Module: wb_test_checker

---
 rtl/wb_check_pkg.sv | 28 ++
 rtl/wb_shadow_regfile.sv | 38 +++
 rtl/wb_test_checker.sv | 149 ++++++++++++++
 tb/tb_wb_test_checker.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_check_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_check_pkg
// Brief   : Shared types and constants for the write-back test checker.
// Revision: 1.0
// ============================================================================
package wb_check_pkg;

    localparam int c_flag_w = 32;
    localparam int c_reg_w  = 5;
    localparam int c_exp_w  = 32;

    localparam logic [c_reg_w-1:0] c_x0_addr = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [c_flag_w-1:0] flag;
        logic [c_reg_w-1:0]  regsel;
        logic [c_exp_w-1:0]  exp;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_shadow_regfile.sv
`default_nettype none
// ============================================================================
// Module  : wb_shadow_regfile
// Brief   : 32x32 shadow of the CPU register file, one write / two async reads.
// Revision: 1.0
// ============================================================================
module wb_shadow_regfile
    import wb_check_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [c_reg_w-1:0] waddr,
    input  logic [31:0]        wdata,
    input  logic [c_reg_w-1:0] raddr_a,
    output logic [31:0]        rdata_a,
    input  logic [c_reg_w-1:0] raddr_b,
    output logic [31:0]        rdata_b
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (waddr != c_x0_addr)) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Reads come straight from the array, so a write shows up one cycle later.
    assign rdata_a = (raddr_a == c_x0_addr) ? '0 : r_regs[raddr_a];
    assign rdata_b = (raddr_b == c_x0_addr) ? '0 : r_regs[raddr_b];

endmodule
`default_nettype wire

// File: rtl/wb_test_checker.sv
`default_nettype none
// ============================================================================
// Module  : wb_test_checker
// Brief   : Watches register write-back and checks a table of expected values.
// Revision: 1.0
// ============================================================================
module wb_test_checker
    import wb_check_pkg::*;
#(
    parameter int NUM_CHECKS     = 16,
    parameter int FLAG_REG       = 20,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int STOP_ON_FAIL   = 0,
    localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_en,
    input  logic [4:0]    wb_addr,
    input  logic [31:0]   wb_data,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [31:0]   cfg_flag,
    input  logic [4:0]    cfg_reg,
    input  logic [31:0]   cfg_exp,
    input  logic [IW:0]   cfg_count,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [IW:0]   fail_count,
    output logic [IW-1:0] first_fail_idx,
    output logic [31:0]   first_fail_got
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW:0]        c_num_checks = (IW + 1)'(NUM_CHECKS);
    localparam logic [IW:0]        c_fail_max   = '1;
    localparam logic [CW-1:0]      c_cyc_last   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_reg_w-1:0] c_flag_addr  = c_reg_w'(FLAG_REG);

    state_t        r_state;
    state_t        w_next_state;
    entry_t        r_table [NUM_CHECKS];
    entry_t        w_entry;
    logic [IW-1:0] r_ptr;
    logic [IW:0]   r_count;
    logic [CW-1:0] r_cycles;
    logic [31:0]   w_flag_val;
    logic [31:0]   w_reg_val;
    logic          w_eval;
    logic          w_mismatch;
    logic          w_last;
    logic          w_complete;
    logic          w_timeout_hit;
    logic [IW:0]   w_fail_next;

    wb_shadow_regfile u_shadow (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (c_flag_addr),
        .rdata_a (w_flag_val),
        .raddr_b (w_entry.regsel),
        .rdata_b (w_reg_val)
    );

    always_ff @(posedge clk) begin
        if (cfg_we && (r_state != ST_RUN) && ({1'b0, cfg_idx} < c_num_checks)) begin
            r_table[cfg_idx] <= {cfg_flag, cfg_reg, cfg_exp};
        end
    end

    assign w_entry       = r_table[r_ptr];
    assign w_eval        = (r_state == ST_RUN) && (r_count != '0) && (w_flag_val == w_entry.flag);
    assign w_mismatch    = w_eval && (w_reg_val != w_entry.exp);
    assign w_last        = w_eval && ({1'b0, r_ptr} == (r_count - 1'b1));
    assign w_complete    = (r_count == '0) || w_last || ((STOP_ON_FAIL != 0) && w_mismatch);
    assign w_timeout_hit = (r_cycles == c_cyc_last);
    assign w_fail_next   = (w_mismatch && (fail_count != c_fail_max)) ? fail_count + 1'b1 : fail_count;
    assign busy          = (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next_state = ST_RUN;
            ST_RUN:           if (w_complete || w_timeout_hit) w_next_state = ST_DONE;
            default:          w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr          <= '0;
            r_count        <= '0;
            r_cycles       <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
        end else if (r_state != ST_RUN) begin
            if (start) begin
                r_ptr          <= '0;
                r_count        <= (cfg_count > c_num_checks) ? c_num_checks : cfg_count;
                r_cycles       <= '0;
                done           <= 1'b0;
                pass           <= 1'b0;
                timeout        <= 1'b0;
                fail_count     <= '0;
                first_fail_idx <= '0;
                first_fail_got <= '0;
            end
        end else begin
            r_cycles <= r_cycles + 1'b1;
            if (w_eval) begin
                r_ptr      <= r_ptr + 1'b1;
                fail_count <= w_fail_next;
                if (w_mismatch && (fail_count == '0)) begin
                    first_fail_idx <= r_ptr;
                    first_fail_got <= w_reg_val;
                end
            end
            // Completion outranks a timeout landing on the same cycle.
            if (w_complete) begin
                done <= 1'b1;
                pass <= (w_fail_next == '0);
            end else if (w_timeout_hit) begin
                done    <= 1'b1;
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_test_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_test_checker
// Brief   : Scoreboard bench for wb_test_checker, normal and stop-on-fail copies.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_wb_test_checker;

    localparam int NC  = 8;
    localparam int TMO = 50;
    localparam int SL  = 50;
    localparam int FR  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [31:0] cfg_flag = '0;
    logic [4:0]  cfg_reg = '0;
    logic [31:0] cfg_exp = '0;
    logic [3:0]  cfg_count = '0;
    logic        start = 1'b0;

    logic        busy0, done0, pass0, tmo0, busy1, done1, pass1, tmo1;
    logic [3:0]  fc0, fc1;
    logic [2:0]  ffi0, ffi1;
    logic [31:0] ffg0, ffg1;

    wb_test_checker #(.NUM_CHECKS(NC), .FLAG_REG(FR), .TIMEOUT_CYCLES(TMO), .STOP_ON_FAIL(0)) dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_flag(cfg_flag), .cfg_reg(cfg_reg),
        .cfg_exp(cfg_exp), .cfg_count(cfg_count), .start(start),
        .busy(busy0), .done(done0), .pass(pass0), .timeout(tmo0),
        .fail_count(fc0), .first_fail_idx(ffi0), .first_fail_got(ffg0));

    wb_test_checker #(.NUM_CHECKS(NC), .FLAG_REG(FR), .TIMEOUT_CYCLES(TMO), .STOP_ON_FAIL(1)) dut_s (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_flag(cfg_flag), .cfg_reg(cfg_reg),
        .cfg_exp(cfg_exp), .cfg_count(cfg_count), .start(start),
        .busy(busy1), .done(done1), .pass(pass1), .timeout(tmo1),
        .fail_count(fc1), .first_fail_idx(ffi1), .first_fail_got(ffg1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          pass;
        bit          tmo;
        int          fails;
        int          fidx;
        logic [31:0] fgot;
        int          lat;
    } exp_t;

    logic [31:0] mregs [32];
    logic [31:0] tflag [NC];
    logic [4:0]  treg  [NC];
    logic [31:0] texp  [NC];
    bit          s_en   [SL];
    logic [4:0]  s_addr [SL];
    logic [31:0] s_data [SL];
    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;
    int          start_cyc = 0;
    bit          pd0 = 1'b0;
    bit          pd1 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the run cycle by cycle; a write becomes visible the cycle after it.
    function automatic exp_t model(input int cnt, input bit stop);
        exp_t        e;
        logic [31:0] r [32];
        logic [31:0] got;
        int          n, p;
        bit          fin, mm;
        e = '{pass: 1'b0, tmo: 1'b0, fails: 0, fidx: 0, fgot: '0, lat: 0};
        for (int i = 0; i < 32; i++) r[i] = mregs[i];
        n   = (cnt > NC) ? NC : cnt;
        p   = 0;
        fin = 1'b0;
        for (int j = 0; j < TMO && !fin; j++) begin
            if (n == 0) begin
                fin = 1'b1; e.pass = 1'b1; e.lat = j + 1;
            end else if (r[FR] == tflag[p]) begin
                got = r[treg[p]];
                mm  = (got != texp[p]);
                if (mm) begin
                    if (e.fails == 0) begin e.fidx = p; e.fgot = got; end
                    e.fails++;
                end
                p++;
                if (p == n || (stop && mm)) begin
                    fin = 1'b1; e.pass = (e.fails == 0); e.lat = j + 1;
                end
            end
            if (!fin && j == TMO - 1) begin
                fin = 1'b1; e.tmo = 1'b1; e.pass = 1'b0; e.lat = TMO;
            end
            if (s_en[j] && s_addr[j] != 5'd0) r[s_addr[j]] = s_data[j];
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input exp_t e, input logic b, input logic p, input logic t,
                       input logic [3:0] fc, input logic [2:0] fi, input logic [31:0] fg);
        chk({nm, "_busy"}, b, 1'b0);
        chk({nm, "_pass"}, p, e.pass);
        chk({nm, "_timeout"}, t, e.tmo);
        chk({nm, "_fail_count"}, fc, e.fails);
        chk({nm, "_first_fail_idx"}, fi, e.fidx);
        chk({nm, "_first_fail_got"}, fg, e.fgot);
        chk({nm, "_latency"}, cyc - start_cyc, e.lat);
    endtask

    always @(negedge clk) begin
        if (rst) pd0 = 1'b0;
        else begin
            if (done0 && !pd0) begin
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL d0_unexpected_done got done=1 expected no pending run");
                end else cmp("d0", q0.pop_front(), busy0, pass0, tmo0, fc0, ffi0, ffg0);
            end
            pd0 = done0;
        end
    end

    always @(negedge clk) begin
        if (rst) pd1 = 1'b0;
        else begin
            if (done1 && !pd1) begin
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL d1_unexpected_done got done=1 expected no pending run");
                end else cmp("d1", q1.pop_front(), busy1, pass1, tmo1, fc1, ffi1, ffg1);
            end
            pd1 = done1;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy0"}, busy0, 1'b0);  chk({tag, "_busy1"}, busy1, 1'b0);
        chk({tag, "_done0"}, done0, 1'b0);  chk({tag, "_done1"}, done1, 1'b0);
        chk({tag, "_pass0"}, pass0, 1'b0);  chk({tag, "_pass1"}, pass1, 1'b0);
        chk({tag, "_tmo0"}, tmo0, 1'b0);    chk({tag, "_tmo1"}, tmo1, 1'b0);
        chk({tag, "_fc0"}, fc0, 4'd0);      chk({tag, "_fc1"}, fc1, 4'd0);
        chk({tag, "_ffi0"}, ffi0, 3'd0);    chk({tag, "_ffi1"}, ffi1, 3'd0);
        chk({tag, "_ffg0"}, ffg0, 32'd0);   chk({tag, "_ffg1"}, ffg1, 32'd0);
    endtask

    task automatic load_entry(input int i, input logic [31:0] f, input logic [4:0] rg, input logic [31:0] x);
        cfg_we = 1'b1; cfg_idx = 3'(i); cfg_flag = f; cfg_reg = rg; cfg_exp = x;
        tick();
        cfg_we = 1'b0;
        tflag[i] = f; treg[i] = rg; texp[i] = x;
    endtask

    task automatic clear_sched();
        for (int j = 0; j < SL; j++) begin
            s_en[j] = 1'b0; s_addr[j] = '0; s_data[j] = '0;
        end
    endtask

    task automatic set_w(input int j, input logic [4:0] a, input logic [31:0] d);
        s_en[j] = 1'b1; s_addr[j] = a; s_data[j] = d;
    endtask

    // Strays (extra start, table write) land only while both copies are still running.
    task automatic do_run(input int cnt, input bit strays);
        exp_t e0, e1;
        int   jmin, js, jc;
        e0 = model(cnt, 1'b0);
        e1 = model(cnt, 1'b1);
        q0.push_back(e0);
        q1.push_back(e1);
        jmin = ((e0.lat < e1.lat) ? e0.lat : e1.lat) - 1;
        js = strays ? int'($urandom_range(0, jmin)) : -1;
        jc = strays ? int'($urandom_range(0, jmin)) : -1;
        cfg_count = 4'(cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        chk("busy0_run", busy0, 1'b1);
        chk("busy1_run", busy1, 1'b1);
        for (int j = 0; j < SL; j++) begin
            wb_en = s_en[j]; wb_addr = s_addr[j]; wb_data = s_data[j];
            start = (j == js);
            if (j == jc) begin
                cfg_we = 1'b1; cfg_idx = 3'($urandom_range(0, NC - 1));
                cfg_flag = $urandom; cfg_reg = 5'($urandom); cfg_exp = $urandom;
            end
            tick();
            cfg_we = 1'b0; start = 1'b0;
            if (s_en[j] && s_addr[j] != 5'd0) mregs[s_addr[j]] = s_data[j];
        end
        wb_en = 1'b0;
        for (int k = 0; k < 5 && (q0.size() + q1.size()) != 0; k++) tick();
        chk("run_drained", q0.size() + q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        for (int i = 0; i < NC; i++) begin tflag[i] = '0; treg[i] = '0; texp[i] = '0; end
        clear_sched();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_zero("por");

        // Two-phase program, all values correct.
        load_entry(0, 2, 1, 500); load_entry(1, 2, 2, 100);
        load_entry(2, 3, 2, 111); load_entry(3, 3, 1, 300);
        clear_sched();
        set_w(0, 1, 500); set_w(1, 2, 100); set_w(2, 20, 2);
        set_w(7, 2, 111); set_w(8, 1, 300); set_w(9, 20, 3);
        do_run(4, 1'b0);

        // Same program, x1 corrupted before the second phase.
        clear_sched();
        set_w(0, 1, 500); set_w(1, 2, 100); set_w(2, 20, 2);
        set_w(7, 2, 111); set_w(8, 1, 301); set_w(9, 20, 3);
        do_run(4, 1'b0);

        // Flag never reaches the first entry: timeout.
        clear_sched();
        set_w(0, 20, 7);
        do_run(4, 1'b0);

        // Reset mid-run aborts silently, then an empty table passes at once.
        cfg_count = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        tick();
        check_zero("midrst");
        clear_sched();
        do_run(0, 1'b0);

        // x0 writes ignored; a write in an entry's evaluation cycle is not seen.
        load_entry(0, 5, 20, 5); load_entry(1, 5, 0, 0); load_entry(2, 6, 3, 9);
        clear_sched();
        set_w(0, 0, 5); set_w(1, 20, 5); set_w(4, 20, 6); set_w(5, 3, 9);
        do_run(3, 1'b0);

        // Mismatches on entries 0 and 2 (stop-on-fail copy stops at entry 0).
        load_entry(0, 1, 1, 9); load_entry(1, 1, 2, 0); load_entry(2, 1, 3, 7);
        clear_sched();
        set_w(0, 1, 4); set_w(1, 20, 1);
        do_run(3, 1'b0);

        // Count above table depth is clamped.
        for (int i = 0; i < NC; i++) load_entry(i, 1, 0, 0);
        clear_sched();
        do_run(15, 1'b0);

        // Completion on the very last budget cycle beats timeout.
        load_entry(0, 8, 0, 0);
        clear_sched();
        set_w(TMO - 2, 20, 8);
        do_run(1, 1'b0);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NC; i++) begin
                logic [4:0] rs;
                case ($urandom_range(0, 4))
                    0: rs = 5'd0; 1: rs = 5'd1; 2: rs = 5'd2; 3: rs = 5'd3; default: rs = 5'd20;
                endcase
                load_entry(i, $urandom_range(0, 3), rs, $urandom_range(0, 3));
            end
            clear_sched();
            for (int j = 0; j < SL; j++) begin
                logic [4:0] a;
                case ($urandom_range(0, 4))
                    0: a = 5'd0; 1: a = 5'd1; 2: a = 5'd2; 3: a = 5'd3; default: a = 5'd20;
                endcase
                if ($urandom_range(0, 3) != 0) set_w(j, a, $urandom_range(0, 3));
            end
            do_run($urandom_range(0, 10), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
